// File: rtl/ps2_player_input.sv
// PS/2 keyboard receiver and key decoder producing frame-latched P1/P2 controls.
// Controls are snapshotted on frame_tick so the physics step sees stable inputs.
//
// state | meaning
// IDLE  | waiting for a start bit (falling edge with data low)
// SHIFT | collecting data, parity and stop bits; timeout armed
module ps2_player_input #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       frame_tick,
  output logic       p1_move_left,
  output logic       p1_move_right,
  output logic       p1_jump,
  output logic       p1_smash,
  output logic       p2_move_left,
  output logic       p2_move_right,
  output logic       p2_jump,
  output logic       p2_smash,
  output logic       ctrl_valid,
  output logic [7:0] scancode,
  output logic       byte_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          bit_in;

  logic [0:0]    state;
  logic [3:0]    bitcnt;
  logic [8:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  logic          ext;
  logic          brk;
  logic [7:0]    held;
  logic [7:0]    cap;
  logic          hit;
  logic [2:0]    idx;
  logic [7:0]    make_set;
  logic [7:0]    raw;
  logic [7:0]    resolved;
  logic [7:0]    ctrl;

  // Sync flops idle high so release from reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state == SHIFT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitcnt     <= 4'd0;
      shreg      <= 9'd0;
      to_cnt     <= '0;
      scancode   <= 8'h00;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !bit_in) begin
            state  <= SHIFT;
            bitcnt <= 4'd1;
          end
        end
        SHIFT: begin
          // Timeout wins over any edge arriving in the same cycle.
          if (timeout) begin
            state  <= IDLE;
            bitcnt <= 4'd0;
            to_cnt <= '0;
            rx_err <= 1'b1;
          end else if (fall) begin
            to_cnt <= '0;
            if (bitcnt == 4'd10) begin
              state  <= IDLE;
              bitcnt <= 4'd0;
              if ((^shreg) && bit_in) begin
                scancode   <= shreg[7:0];
                byte_valid <= 1'b1;
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              shreg  <= {bit_in, shreg[8:1]};
              bitcnt <= bitcnt + 4'd1;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control index: bit 0..3 = P1 left/right/jump/smash, 4..7 = P2.
  always_comb begin
    hit = 1'b1;
    idx = 3'd0;
    if (!ext) begin
      case (scancode)
        8'h1C:   idx = 3'd0;
        8'h23:   idx = 3'd1;
        8'h1D:   idx = 3'd2;
        8'h1B:   idx = 3'd3;
        default: hit = 1'b0;
      endcase
    end else begin
      case (scancode)
        8'h6B:   idx = 3'd4;
        8'h74:   idx = 3'd5;
        8'h75:   idx = 3'd6;
        8'h72:   idx = 3'd7;
        default: hit = 1'b0;
      endcase
    end
  end

  assign make_set = (byte_valid && hit && !brk) ? (8'b1 << idx) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      held <= 8'h00;
    end else if (byte_valid) begin
      if (scancode == 8'hE0) begin
        ext <= 1'b1;
      end else if (scancode == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        if (hit) held[idx] <= ~brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign raw = held | cap;

  always_comb begin
    resolved    = raw;
    resolved[0] = raw[0] & ~raw[1];
    resolved[1] = raw[1] & ~raw[0];
    resolved[4] = raw[4] & ~raw[5];
    resolved[5] = raw[5] & ~raw[4];
  end

  // A make decoded on the tick cycle is not in raw yet, so it survives into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap        <= 8'h00;
      ctrl       <= 8'h00;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= frame_tick;
      if (frame_tick) begin
        cap  <= make_set;
        ctrl <= resolved;
      end else begin
        cap <= cap | make_set;
      end
    end
  end

  assign p1_move_left  = ctrl[0];
  assign p1_move_right = ctrl[1];
  assign p1_jump       = ctrl[2];
  assign p1_smash      = ctrl[3];
  assign p2_move_left  = ctrl[4];
  assign p2_move_right = ctrl[5];
  assign p2_jump       = ctrl[6];
  assign p2_smash      = ctrl[7];

endmodule

// File: tb/tb_ps2_player_input.sv
// Self-checking bench for ps2_player_input: key table vectors, corner sequences,
// and random key/tick traffic against a behavioural key-state model.
module tb_ps2_player_input;

  localparam int T    = 100;
  localparam int HALF = 8;

  localparam logic [7:0] KEYS [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72};
  localparam logic [7:0] POOL [11] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72,
                                       8'hE0, 8'hF0, 8'hE0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       frame_tick;
  logic       p1_move_left, p1_move_right, p1_jump, p1_smash;
  logic       p2_move_left, p2_move_right, p2_jump, p2_smash;
  logic       ctrl_valid;
  logic [7:0] scancode;
  logic       byte_valid;
  logic       rx_err;
  logic [7:0] outs;

  ps2_player_input #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .frame_tick(frame_tick),
    .p1_move_left(p1_move_left), .p1_move_right(p1_move_right),
    .p1_jump(p1_jump), .p1_smash(p1_smash),
    .p2_move_left(p2_move_left), .p2_move_right(p2_move_right),
    .p2_jump(p2_jump), .p2_smash(p2_smash),
    .ctrl_valid(ctrl_valid), .scancode(scancode),
    .byte_valid(byte_valid), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  assign outs = {p2_smash, p2_jump, p2_move_right, p2_move_left,
                 p1_smash, p1_jump, p1_move_right, p1_move_left};

  int checks = 0;
  int failures = 0;
  int bv_cnt = 0;
  int err_cnt = 0;
  int excl_bad = 0;

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (rx_err) err_cnt++;
    if (byte_valid && rx_err) excl_bad++;
  end

  // Behavioural model: which keys are down, which were pressed this frame.
  bit [7:0]   m_held, m_cap, m_out;
  bit         m_ext, m_brk;
  logic [7:0] last_valid;

  typedef struct {
    int              nb;
    logic [2:0][7:0] b;
    logic [7:0]      exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int key_index(bit ext, logic [7:0] code);
    int off = ext ? 4 : 0;
    for (int k = 0; k < 4; k++)
      if (KEYS[k + off] == code) return k + off;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = key_index(m_ext, b);
      if (k >= 0) begin
        m_held[k] = !m_brk;
        if (!m_brk) m_cap[k] = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_tick();
    bit [7:0] r;
    r = m_held | m_cap;
    for (int p = 0; p < 2; p++) begin
      m_out[4*p]   = r[4*p] && !r[4*p+1];
      m_out[4*p+1] = r[4*p+1] && !r[4*p];
      m_out[4*p+2] = r[4*p+2];
      m_out[4*p+3] = r[4*p+3];
    end
    m_cap = '0;
  endtask

  function automatic logic [10:0] frame_of(logic [7:0] b, bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk); ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int bv0;
    bv0 = bv_cnt;
    send_bits(frame_of(b, 1'b0), 0, 10);
    repeat (2) @(negedge clk);
    check("byte_valid_count", bv_cnt, bv0 + 1);
    check("scancode", scancode, b);
    last_valid = b;
    model_byte(b);
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    model_tick();
    check("ctrl_valid_high", ctrl_valid, 1);
    check("outs_after_tick", outs, m_out);
    @(negedge clk);
    check("ctrl_valid_low", ctrl_valid, 0);
    check("outs_stable", outs, m_out);
  endtask

  function automatic vec_t mk(int nb, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] e);
    vec_t v;
    v.nb = nb; v.b[0] = a; v.b[1] = b; v.b[2] = c; v.exp = e;
    return v;
  endfunction

  initial begin
    int e0, b0, first, found;
    logic [10:0] fr;

    vecs[0]  = mk(1, 8'h1D, 8'h00, 8'h00, 8'h04);
    vecs[1]  = mk(2, 8'hF0, 8'h1D, 8'h00, 8'h00);
    vecs[2]  = mk(3, 8'h1B, 8'hF0, 8'h1B, 8'h08);
    vecs[3]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[4]  = mk(2, 8'hE0, 8'h6B, 8'h00, 8'h10);
    vecs[5]  = mk(1, 8'h6B, 8'h00, 8'h00, 8'h10);
    vecs[6]  = mk(3, 8'hE0, 8'hF0, 8'h6B, 8'h00);
    vecs[7]  = mk(2, 8'h1C, 8'h23, 8'h00, 8'h00);
    vecs[8]  = mk(2, 8'hF0, 8'h23, 8'h00, 8'h01);
    vecs[9]  = mk(2, 8'hF0, 8'h1C, 8'h00, 8'h00);
    vecs[10] = mk(3, 8'h1D, 8'h1D, 8'h1D, 8'h04);
    vecs[11] = mk(2, 8'hF0, 8'h1D, 8'h00, 8'h00);
    vecs[12] = mk(2, 8'hE0, 8'h74, 8'h00, 8'h20);
    vecs[13] = mk(3, 8'hE0, 8'hF0, 8'h74, 8'h00);

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; frame_tick = 1'b0;
    m_held = '0; m_cap = '0; m_out = '0; m_ext = 0; m_brk = 0; last_valid = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 8'h00);
    check("reset_scancode", scancode, 8'h00);
    check("reset_pulses", {ctrl_valid, byte_valid, rx_err}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[j]);
      do_tick();
      check($sformatf("table_vec%0d", i), outs, vecs[i].exp);
    end

    // Parity error: rejected, scancode and controls untouched
    e0 = err_cnt; b0 = bv_cnt;
    send_bits(frame_of(8'h1D, 1'b1), 0, 10);
    repeat (2) @(negedge clk);
    check("parity_err_count", err_cnt, e0 + 1);
    check("parity_no_byte", bv_cnt, b0);
    check("parity_scancode_kept", scancode, last_valid);
    do_tick();
    check("parity_outs", outs, 8'h00);

    // Timeout after 5 bits; counted in negedges from the last pin fall
    e0 = err_cnt;
    fr = frame_of(8'h1D, 1'b0);
    send_bits(fr, 0, 3);
    @(negedge clk); ps2_data = fr[4];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    first = 0;
    for (int c = 1; c <= T + 20 && first == 0; c++) begin
      @(negedge clk);
      if (c == HALF) ps2_clk = 1'b1;
      if (rx_err) first = c;
    end
    check("timeout_latency", first, T + 3);
    repeat (4) @(negedge clk);
    check("timeout_err_count", err_cnt, e0 + 1);
    send_byte(8'h1D);
    do_tick();
    check("after_timeout_jump", p1_jump, 1'b1);
    send_byte(8'hF0); send_byte(8'h1D);
    do_tick();

    // Make decoded in the tick cycle is deferred to the next frame
    fr = frame_of(8'h1B, 1'b0);
    send_bits(fr, 0, 9);
    @(negedge clk); ps2_data = fr[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == HALF) ps2_clk = 1'b1;
      if (frame_tick) begin
        frame_tick = 1'b0;
        model_tick();
        model_byte(8'h1B);
        check("samecycle_ctrl_valid", ctrl_valid, 1);
        check("samecycle_outs", outs, 8'h00);
      end else if (byte_valid && found == 0) begin
        found = 1;
        frame_tick = 1'b1;
      end
    end
    check("samecycle_seen", found, 1);
    send_byte(8'hF0); send_byte(8'h1B);
    do_tick();
    check("samecycle_retained", outs, 8'h08);
    do_tick();
    check("samecycle_cleared", outs, 8'h00);

    // Random key traffic against the model
    for (int n = 0; n < 80; n++) begin
      int r, k;
      r = $urandom_range(0, 9);
      if (r < 3) do_tick();
      else begin
        k = $urandom_range(0, 11);
        if (k == 11) send_byte(8'($urandom_range(0, 255)));
        else send_byte(POOL[k]);
      end
    end
    do_tick();

    // Reset in the middle of bit 6
    send_byte(8'h1D);
    do_tick();
    fr = frame_of(8'h1D, 1'b0);
    send_bits(fr, 0, 5);
    @(negedge clk); ps2_data = fr[6];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", outs, 8'h00);
    check("midreset_scancode", scancode, 8'h00);
    check("midreset_pulses", {ctrl_valid, byte_valid, rx_err}, 3'b000);
    m_held = '0; m_cap = '0; m_out = '0; m_ext = 0; m_brk = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF - 5) @(negedge clk);
    ps2_clk = 1'b1;
    send_bits(fr, 7, 10);
    repeat (T + 20) @(negedge clk);
    check("midreset_outs_hold", outs, 8'h00);
    send_byte(8'hE0);
    send_byte(8'h74);
    do_tick();
    check("midreset_p2_right", p2_move_right, 1'b1);

    check("valid_err_exclusive", excl_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
